demux1to7_reg: RTL and testbench

Registered 1-to-7 demultiplexer: the write-side counterpart of the team's 7-to-1 selector. It steers a single data bit into one of seven storage bits chosen by a 3-bit select. It also offers a fill command that broadcasts one bit into all seven slots over seven cycles. It sits between board switches/keys and LEDs in the lab top level, and its output vector is what the 7-to-1 selector reads back.

---
 rtl/demux1to7_reg_pkg.sv | 15 +
 rtl/demux1to7_reg_if.sv | 16 +
 rtl/demux1to7_reg_rise_edge.sv | 38 +++
 rtl/demux1to7_reg.sv | 101 ++++++++++
 tb/tb_demux1to7_reg.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/demux1to7_reg_pkg.sv
// Shared constants and FSM encoding for the registered 1-to-7 demultiplexer.
package demux1to7_reg_pkg;

  localparam int NUM_OUT = 7;
  localparam int SEL_W   = 3;

  localparam logic [SEL_W-1:0] LAST_IDX    = 3'd6;
  localparam logic [SEL_W-1:0] SEL_INVALID = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/demux1to7_reg_if.sv
// Bus between the switch/key side (master) and the demux storage (slave).
interface demux1to7_reg_if;
  import demux1to7_reg_pkg::*;

  logic [SEL_W-1:0]   sel;
  logic               din;
  logic               wr;
  logic               fill;
  logic [NUM_OUT-1:0] q;
  logic               busy;
  logic               err;

  modport master (output sel, din, wr, fill, input q, busy, err);
  modport slave  (input sel, din, wr, fill, output q, busy, err);

endinterface

// File: rtl/demux1to7_reg_rise_edge.sv
// Rising-edge detector for a level strobe; DEMUX_STROBE_SYNC_EN adds a 2-flop synchronizer in front.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

`ifdef DEMUX_STROBE_SYNC_EN
  logic [1:0] sync_q;
  logic       hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in};
      hist_q <= sync_q[1];
    end
  end

  assign pulse = sync_q[1] & ~hist_q;
`else
  logic hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= in;
    end
  end

  assign pulse = in & ~hist_q;
`endif

endmodule

// File: rtl/demux1to7_reg.sv
// Registered 1-to-7 demux with a 7-cycle broadcast fill; busy/err are registered outputs.
// Strobe synchronization is selected by DEMUX_STROBE_SYNC_EN inside rise_edge.
module demux1to7_reg
  import demux1to7_reg_pkg::*;
#(
  parameter int NUM_OUT = 7,
  parameter int SEL_W   = 3
) (
  input logic            CLOCK_50,
  input logic            reset,
  demux1to7_reg_if.slave bus
);

  logic wr_req;
  logic fill_req;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               fill_bit_q, fill_bit_d;
  logic [NUM_OUT-1:0] q_q, q_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  rise_edge u_wr_edge (
    .clk   (CLOCK_50),
    .reset (reset),
    .in    (bus.wr),
    .pulse (wr_req)
  );

  rise_edge u_fill_edge (
    .clk   (CLOCK_50),
    .reset (reset),
    .in    (bus.fill),
    .pulse (fill_req)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      fill_bit_q <= 1'b0;
      q_q        <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_bit_q <= fill_bit_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_bit_d = fill_bit_q;
    q_d        = q_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // Fill has priority; a write arriving alongside it is rejected.
        if (fill_req) begin
          state_d    = FILL;
          idx_d      = '0;
          fill_bit_d = bus.din;
          err_d      = wr_req;
        end else if (wr_req) begin
          if (bus.sel == SEL_INVALID) begin
            err_d = 1'b1;
          end else begin
            q_d[bus.sel] = bus.din;
          end
        end
      end
      FILL: begin
        q_d[idx_q] = fill_bit_q;
        err_d      = wr_req;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FILL);
  end

  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_demux1to7_reg.sv
// Directed bench for demux1to7_reg with a per-cycle expected-state queue.
module tb_demux1to7_reg;

  logic clk = 1'b0;
  logic reset;

  demux1to7_reg_if bus ();

  demux1to7_reg dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] q;
    logic       busy;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Push the state expected after the next rising edge, then compare it 1 time unit after that edge.
  task automatic step(input string tag, input logic [6:0] eq, input logic eb, input logic ee);
    exp_t e;
    e.q = eq; e.busy = eb; e.err = ee; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    assert (bus.q === e.q)
      else begin bad++; $error("FAIL %s q: got %b want %b", e.tag, bus.q, e.q); end
    total++;
    assert (bus.busy === e.busy)
      else begin bad++; $error("FAIL %s busy: got %b want %b", e.tag, bus.busy, e.busy); end
    total++;
    assert (bus.err === e.err)
      else begin bad++; $error("FAIL %s err: got %b want %b", e.tag, bus.err, e.err); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] exp_q;

    reset    = 1'b1;
    bus.sel  = 3'd0;
    bus.din  = 1'b0;
    bus.wr   = 1'b0;
    bus.fill = 1'b0;
    step("reset0", 7'b0, 1'b0, 1'b0);
    step("reset1", 7'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Single write to slot 3
    bus.sel = 3'd3; bus.din = 1'b1; bus.wr = 1'b1;
    step("wr_sel3", 7'b0001000, 1'b0, 1'b0);
    bus.wr = 1'b0;
    step("wr_sel3_after", 7'b0001000, 1'b0, 1'b0);

    // Held wr performs exactly one write; later din change is ignored
    bus.sel = 3'd2; bus.din = 1'b1; bus.wr = 1'b1;
    step("held_first", 7'b0001100, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step("held_hi", 7'b0001100, 1'b0, 1'b0);
    bus.din = 1'b0;
    step("held_din0_a", 7'b0001100, 1'b0, 1'b0);
    step("held_din0_b", 7'b0001100, 1'b0, 1'b0);
    bus.wr = 1'b0;
    step("held_release", 7'b0001100, 1'b0, 1'b0);

    // Invalid select rejected with a one-cycle err
    bus.sel = 3'd7; bus.din = 1'b1; bus.wr = 1'b1;
    step("sel7_err", 7'b0001100, 1'b0, 1'b1);
    bus.wr = 1'b0;
    step("sel7_clear", 7'b0001100, 1'b0, 1'b0);

    // Fill of ones from a cleared vector, din flipped after capture
    reset = 1'b1;
    step("reset_pre_fill", 7'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.din = 1'b1; bus.fill = 1'b1;
    step("fill_enter", 7'b0, 1'b1, 1'b0);
    bus.fill = 1'b0; bus.din = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_q = 7'((1 << (i + 1)) - 1);
      step("fill_walk", exp_q, (i < 6), 1'b0);
    end
    step("fill_done", 7'h7F, 1'b0, 1'b0);

    // Simultaneous fill+wr, a mid-fill write, and a mid-fill fill request
    reset = 1'b1;
    step("reset_pre_fw", 7'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.sel = 3'd6; bus.din = 1'b1; bus.fill = 1'b1; bus.wr = 1'b1;
    step("fw_enter", 7'b0, 1'b1, 1'b1);
    bus.fill = 1'b0; bus.wr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.wr   = (i == 2);
      bus.fill = (i == 4);
      exp_q = 7'((1 << (i + 1)) - 1);
      step("fw_walk", exp_q, (i < 6), (i == 2));
    end
    bus.wr = 1'b0; bus.fill = 1'b0;
    step("fw_done", 7'h7F, 1'b0, 1'b0);

    // Reset in the middle of a fill, then a normal write
    reset = 1'b1;
    step("reset_pre_mid", 7'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.din = 1'b1; bus.fill = 1'b1;
    step("mid_enter", 7'b0, 1'b1, 1'b0);
    bus.fill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q = 7'((1 << (i + 1)) - 1);
      step("mid_walk", exp_q, 1'b1, 1'b0);
    end
    reset = 1'b1;
    step("mid_reset", 7'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step("mid_idle", 7'b0, 1'b0, 1'b0);
    bus.sel = 3'd0; bus.din = 1'b1; bus.wr = 1'b1;
    step("post_reset_wr", 7'b0000001, 1'b0, 1'b0);
    bus.wr = 1'b0;
    step("post_reset_idle", 7'b0000001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
